pc_gen: RTL

Parametrised program-counter generator for the fetch stage. It drives the instruction-fetch address and the instruction-memory chip enable. It supports:
- sequential stepping;
- stall hold;
- branch/jump redirect;
- exception redirect.

Redirects that arrive while the pipeline is stalled are buffered and applied when the stall releases. It sits between the control/hazard logic and the instruction ROM.

---
 rtl/pc_gen_pkg.sv | 27 ++
 rtl/pc_redirect_buf.sv | 60 ++++++
 rtl/pc_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// chip-enable encoding, default vectors and the PC source selection.
package pc_gen_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int          INST_ADDR_BUS_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0020;

  // Fetch state; the enabled state is what drives the memory chip enable.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_EXC,
    SRC_BRANCH,
    SRC_PEND,
    SRC_RESET
  } pc_src_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while fetch was stalled. Exception-tagged
// entries win over branches; a newer branch replaces an older branch.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W  = INST_ADDR_BUS_W,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEFAULT_EXC_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              stall_i,
  input  logic              exc_i,
  input  logic              br_i,
  input  logic [ADDR_W-1:0] br_tgt_i,
  output logic              pend_o,
  output logic              pend_exc_o,
  output logic [ADDR_W-1:0] pend_tgt_o
);

  logic              pend_q,     pend_d;
  logic              pend_exc_q, pend_exc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  always_comb begin
    pend_d     = pend_q;
    pend_exc_d = pend_exc_q;
    pend_tgt_d = pend_tgt_q;
    if (!run_i || !stall_i) begin
      // Any unstalled edge consumes or supersedes the entry; idle never buffers.
      pend_d     = 1'b0;
      pend_exc_d = 1'b0;
    end else if (exc_i) begin
      pend_d     = 1'b1;
      pend_exc_d = 1'b1;
      pend_tgt_d = EXC_VEC;
    end else if (br_i && !(pend_q && pend_exc_q)) begin
      pend_d     = 1'b1;
      pend_exc_d = 1'b0;
      pend_tgt_d = br_tgt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_exc_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_exc_q <= pend_exc_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_exc_o = pend_exc_q;
  assign pend_tgt_o = pend_tgt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential step, stall hold, branch and
// exception redirect, with stalled redirects buffered until release.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEFAULT_EXC_VEC),
  parameter int                STEP       = 4,
  parameter int                ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              exc_flag_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o,
  output logic              pend_o
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  run_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  pc_src_e           src;

  logic              run;
  logic [ADDR_W-1:0] br_tgt_aligned;
  logic              br_low_set;
  logic              pend_v, pend_exc;
  logic [ADDR_W-1:0] pend_tgt;

  assign run            = (state_q == ST_RUN);
  assign br_tgt_aligned = branch_target_i & ~LOW_MASK;
  assign br_low_set     = |(branch_target_i & LOW_MASK);

  pc_redirect_buf #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .stall_i    (stall_i),
    .exc_i      (exc_flag_i),
    .br_i       (branch_flag_i),
    .br_tgt_i   (br_tgt_aligned),
    .pend_o     (pend_v),
    .pend_exc_o (pend_exc),
    .pend_tgt_o (pend_tgt)
  );

  always_comb begin
    state_d    = ST_RUN;
    src        = SRC_HOLD;
    misalign_d = 1'b0;
    if (!run) begin
      src = SRC_RESET;
    end else begin
      if (exc_flag_i)         src = stall_i ? SRC_HOLD : SRC_EXC;
      else if (branch_flag_i) src = stall_i ? SRC_HOLD : SRC_BRANCH;
      else if (stall_i)       src = SRC_HOLD;
      else if (pend_v)        src = SRC_PEND;
      else                    src = SRC_SEQ;
      // Flag only a branch target that is actually taken or buffered.
      misalign_d = branch_flag_i && !exc_flag_i && br_low_set &&
                   !(stall_i && pend_v && pend_exc);
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_RESET:  pc_d = RESET_VEC;
      SRC_EXC:    pc_d = EXC_VEC;
      SRC_BRANCH: pc_d = br_tgt_aligned;
      SRC_PEND:   pc_d = pend_tgt;
      SRC_SEQ:    pc_d = pc_q + ADDR_W'(STEP);
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = run ? CHIP_ENABLE : CHIP_DISABLE;
  assign misalign_o = misalign_q;
  assign pend_o     = pend_v;

endmodule
